iq_dac_packer: RTL and testbench

- Sits directly downstream of the transmitter's pulse-shaping filter.
- Consumes the signed 16-bit real/imag sample pair whenever the filter marks it valid, and buffers pairs in a small FIFO.
- Serialises each pair onto a single 16-bit DAC bus (I word then Q word) under a valid/ready handshake.
- Absorbs the rate mismatch between filter output and DAC interface and flags dropped samples.

---
 rtl/iq_dac_packer.sv | 126 ++++++++++++
 tb/tb_iq_dac_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iq_dac_packer.sv
// Buffers filtered IQ sample pairs in a FIFO and serialises each pair onto a 16-bit DAC bus,
// I word then Q word, under a valid/ready handshake. Dropped input pairs raise a sticky flag.
module iq_dac_packer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned OFFSET_BINARY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       real_in,
  input  logic [15:0]       imag_in,
  input  logic              dac_ready,
  output logic [15:0]       dac_data,
  output logic              dac_valid,
  output logic              dac_iq_sel,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LevelOne  = (ADDR_W + 1)'(1);
  localparam logic [15:0]     IdleWord  = (OFFSET_BINARY != 0) ? 16'h8000 : 16'h0000;

  typedef enum logic [1:0] {StIdle, StSendI, StSendQ} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, rptr_nxt;
  logic [ADDR_W:0]     level_q, level_d;
  logic [15:0]         data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                pop, wr_en, full;

  function automatic logic [15:0] to_dac(input logic [15:0] w);
    return (OFFSET_BINARY != 0) ? {~w[15], w[14:0]} : w;
  endfunction

  assign full     = (level_q == LevelFull);
  assign pop      = (state_q == StSendQ) && dac_ready;
  assign wr_en    = in_valid && (!full || pop);
  assign rptr_nxt = rptr_q + 1'b1;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (pop)   rptr_d = rptr_nxt;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (in_valid && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          state_d = StSendI;
          data_d  = to_dac(mem_q[rptr_q][31:16]);
        end
      end
      StSendI: begin
        if (dac_ready) begin
          state_d = StSendQ;
          data_d  = to_dac(mem_q[rptr_q][15:0]);
        end
      end
      StSendQ: begin
        if (dac_ready) begin
          if (level_q > LevelOne) begin
            state_d = StSendI;
            data_d  = to_dac(mem_q[rptr_nxt][31:16]);
          end else if (wr_en) begin
            // Single entry popped while a new pair arrives: bypass the not-yet-written slot.
            state_d = StSendI;
            data_d  = to_dac(real_in);
          end else begin
            state_d = StIdle;
            data_d  = IdleWord;
          end
        end
      end
      default: begin
        state_d = StIdle;
        data_d  = IdleWord;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      data_q  <= IdleWord;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem_q[wptr_q] <= {real_in, imag_in};
  end

  assign dac_data   = data_q;
  assign dac_valid  = (state_q != StIdle);
  assign dac_iq_sel = (state_q == StSendQ);
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_iq_dac_packer.sv
// Directed bench for iq_dac_packer: reset, latency, back-pressure, overflow, full-with-pop,
// single-entry bypass and mid-transfer reset, plus an offset-binary instance.
module tb_iq_dac_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] real_in, imag_in;
  logic        dac_ready;
  logic [15:0] dac_data, ob_data;
  logic        dac_valid, dac_iq_sel, overflow;
  logic        ob_valid, ob_sel, ob_ovf;
  logic [4:0]  fifo_level, ob_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iq_dac_packer #(.DEPTH(16), .ADDR_W(4), .OFFSET_BINARY(0)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .real_in    (real_in),
    .imag_in    (imag_in),
    .dac_ready  (dac_ready),
    .dac_data   (dac_data),
    .dac_valid  (dac_valid),
    .dac_iq_sel (dac_iq_sel),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  iq_dac_packer #(.DEPTH(16), .ADDR_W(4), .OFFSET_BINARY(1)) u_dut_ob (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .real_in    (real_in),
    .imag_in    (imag_in),
    .dac_ready  (dac_ready),
    .dac_data   (ob_data),
    .dac_valid  (ob_valid),
    .dac_iq_sel (ob_sel),
    .fifo_level (ob_level),
    .overflow   (ob_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs set before step() are sampled at the next rising edge; outputs are read 1ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    real_in   = 16'h1111;
    imag_in   = 16'h2222;
    dac_ready = 1'b1;

    // Reset held three cycles with in_valid asserted
    repeat (3) step();
    check_eq("rst_valid", 32'(dac_valid), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_data", 32'(dac_data), 32'h0000);
    check_eq("rst_ob_data", 32'(ob_data), 32'h8000);
    check_eq("rst_ob_flags", {26'd0, ob_valid, ob_sel, ob_ovf, 3'd0}, 32'd0);
    check_eq("rst_ob_level", 32'(ob_level), 32'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    step();

    // Single pair latency
    in_valid = 1'b1; real_in = 16'h1234; imag_in = 16'hFEDC;
    step();
    in_valid = 1'b0;
    check_eq("sp_e0_level", 32'(fifo_level), 32'd1);
    check_eq("sp_e0_valid", 32'(dac_valid), 32'd0);
    step();
    check_eq("sp_e1_i", {15'd0, dac_valid, dac_iq_sel, dac_data}, {15'd0, 1'b1, 1'b0, 16'h1234});
    check_eq("sp_e1_ob", 32'(ob_data), 32'h9234);
    step();
    check_eq("sp_e2_q", {15'd0, dac_valid, dac_iq_sel, dac_data}, {15'd0, 1'b1, 1'b1, 16'hFEDC});
    check_eq("sp_e2_ob", 32'(ob_data), 32'h7EDC);
    step();
    check_eq("sp_e3_valid", 32'(dac_valid), 32'd0);
    check_eq("sp_e3_level", 32'(fifo_level), 32'd0);
    check_eq("sp_e3_data", 32'(dac_data), 32'h0000);
    check_eq("sp_e3_ob", 32'(ob_data), 32'h8000);

    // Back-pressure during SEND_I
    dac_ready = 1'b0;
    in_valid = 1'b1; real_in = 16'h1234; imag_in = 16'hFEDC;
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_hold", {15'd0, dac_valid, dac_iq_sel, dac_data}, {15'd0, 1'b1, 1'b0, 16'h1234});
    end
    dac_ready = 1'b1;
    step();
    check_eq("bp_q", {15'd0, dac_valid, dac_iq_sel, dac_data}, {15'd0, 1'b1, 1'b1, 16'hFEDC});
    step();
    check_eq("bp_done", 32'(dac_valid), 32'd0);

    // Single-entry pop with simultaneous write: no gap between pairs
    in_valid = 1'b1; real_in = 16'h1111; imag_in = 16'h2222;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("byp_q1", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b1, 16'h2222});
    in_valid = 1'b1; real_in = 16'h3333; imag_in = 16'h4444;
    step();
    in_valid = 1'b0;
    check_eq("byp_i2", {15'd0, dac_valid, dac_iq_sel, dac_data}, {15'd0, 1'b1, 1'b0, 16'h3333});
    check_eq("byp_level", 32'(fifo_level), 32'd1);
    step();
    check_eq("byp_q2", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b1, 16'h4444});
    step();
    check_eq("byp_done", {30'd0, dac_valid, fifo_level == 5'd0}, 32'd1);

    // Overflow: 17 pairs while stalled, then drain 1..16 in order
    dac_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; real_in = 16'hA000 + 16'(i); imag_in = 16'h5000 + 16'(i);
      step();
      if (i == 15) check_eq("ovf_before", 32'(overflow), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("ovf_level", 32'(fifo_level), 32'd16);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    dac_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_eq("drain_i", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b0, 16'hA000 + 16'(k)});
      step();
      check_eq("drain_q", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b1, 16'h5000 + 16'(k)});
      step();
    end
    check_eq("drain_done", {30'd0, dac_valid, fifo_level == 5'd0}, 32'd1);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a write landing on the SEND_Q pop cycle
    do_reset();
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    dac_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; real_in = 16'hC000 + 16'(i); imag_in = 16'h3000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    dac_ready = 1'b1;
    step();
    check_eq("fp_sendq", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b1, 16'h3000});
    in_valid = 1'b1; real_in = 16'hD0D0; imag_in = 16'h0D0D;
    step();
    in_valid = 1'b0;
    dac_ready = 1'b0;
    check_eq("fp_level", 32'(fifo_level), 32'd16);
    check_eq("fp_ovf", 32'(overflow), 32'd0);
    check_eq("fp_next_i", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b0, 16'hC001});
    dac_ready = 1'b1;
    repeat (30) step();
    check_eq("fp_last_i", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b0, 16'hD0D0});
    step();
    check_eq("fp_last_q", {15'd0, dac_iq_sel, dac_data}, {15'd0, 1'b1, 16'h0D0D});
    step();
    check_eq("fp_done", 32'(dac_valid), 32'd0);

    // Reset while in SEND_Q with five pairs buffered
    dac_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; real_in = 16'hE000 + 16'(i); imag_in = 16'hE100 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    dac_ready = 1'b1;
    step();
    dac_ready = 1'b0;
    check_eq("mr_sendq", {15'd0, dac_iq_sel, fifo_level}, {15'd0, 1'b1, 5'd5});
    do_reset();
    check_eq("mr_valid", 32'(dac_valid), 32'd0);
    check_eq("mr_level", 32'(fifo_level), 32'd0);
    check_eq("mr_out", {15'd0, dac_iq_sel, dac_data}, 32'd0);
    dac_ready = 1'b1;
    in_valid = 1'b1; real_in = 16'h7777; imag_in = 16'h8888;
    step();
    in_valid = 1'b0;
    step();
    check_eq("mr_new_i", {15'd0, dac_valid, dac_iq_sel, dac_data}, {15'd0, 1'b1, 1'b0, 16'h7777});
    step();
    check_eq("mr_new_q", {15'd0, dac_valid, dac_iq_sel, dac_data}, {15'd0, 1'b1, 1'b1, 16'h8888});
    step();
    check_eq("mr_done", {30'd0, dac_valid, fifo_level == 5'd0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
